// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x WIDTH general-purpose register file.
// Two combinational read ports and one rising-edge write port.
// Register 0 is hardwired to zero. With BYPASS=1 a same-cycle write is
// forwarded to any read port whose address matches.
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);

    localparam int NREG = 2 ** ADDR_W;
    localparam bit BYP  = (BYPASS != 0);

    logic [WIDTH-1:0] regs [0:NREG-1];
    logic             we;

    // Write qualifier. An unknown address makes this unknown, which the
    // if() in the write block treats as false, so register 0 stays untouched.
    always_comb begin
        we = RegWrite && (WriteReg != '0);
    end

    // Register array: asynchronous clear, rising-edge write, entry 0 never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '{default: '0};
        end else if (we) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // Read port 1: stored value, zero for register 0, optional forward, forced 0 in reset.
    always_comb begin
        ReadData1 = regs[ReadReg1];
        if (ReadReg1 == '0) begin
            ReadData1 = '0;
        end
        if (BYP && we && (WriteReg == ReadReg1)) begin
            ReadData1 = WriteData;
        end
        if (reset) begin
            ReadData1 = '0;
        end
    end

    // Read port 2: same structure as port 1.
    always_comb begin
        ReadData2 = regs[ReadReg2];
        if (ReadReg2 == '0) begin
            ReadData2 = '0;
        end
        if (BYP && we && (WriteReg == ReadReg2)) begin
            ReadData2 = WriteData;
        end
        if (reset) begin
            ReadData2 = '0;
        end
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle/pipelined datapath.
- Provides two combinational read ports. The read data feeds the 32-bit 4:1 operand/forwarding mux directly: ReadData1/ReadData2 go to its Data0 input.
- One synchronous write port is driven from write-back.
- Register 0 is hardwired to zero.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- ADDR_W, 5, register address width; number of registers = 2**ADDR_W.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = reads return the stored value only.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- RegWrite  input  1  write enable for the write port.
- WriteReg  input  ADDR_W  destination register address.
- WriteData  input  WIDTH  data to write.
- ReadReg1  input  ADDR_W  read port 1 address.
- ReadReg2  input  ADDR_W  read port 2 address.
- ReadData1  output  WIDTH  read port 1 data (to operand mux Data0, port A).
- ReadData2  output  WIDTH  read port 2 data (to operand mux Data0, port B).

Behaviour:
- Reset:
  - reset=1 clears all 2**ADDR_W registers to 0 immediately, without waiting for clk.
  - While reset is high, ReadData1 and ReadData2 = 0 and writes are ignored.
  - Deassertion takes effect at the next rising clk edge.
- Write:
  - On rising clk with reset=0 and RegWrite=1, reg[WriteReg] <= WriteData.
  - If WriteReg==0 the write is discarded; reg[0] is always 0.
  - RegWrite=0 leaves every register unchanged.
- Read:
  - Purely combinational, zero-cycle latency: ReadDataN = reg[ReadRegN].
  - ReadRegN==0 always returns 0, irrespective of any write activity.
- Bypass, BYPASS=1 only:
  - If RegWrite=1, WriteReg!=0 and WriteReg==ReadRegN, then ReadDataN = WriteData in the same cycle, before the edge.
  - Both ports may bypass simultaneously when both addresses match WriteReg.
- BYPASS=0:
  - ReadDataN shows the old value until the write edge.
  - The new value is visible immediately after the edge.
- Simultaneous events:
  - Both read ports may address the same register; both return the same value.
  - Read and write to different registers do not interact.
- Reset mid-operation: a write pending on the same edge as reset assertion is lost; the register reads 0.
- X-safety:
  - Write enable with an unknown address must not corrupt register 0.
  - Unknown write data is stored only into the addressed register.
- No internal state other than the register array. No state machine. No handshake.

Test Plan:
- Reset: preload reg5=32'hF0F0F0F0, assert reset asynchronously between edges -> ReadData1 (ReadReg1=5) = 0 within the same timestep; all 32 registers read 0 after release.
- Basic write/read: RegWrite=1, WriteReg=3, WriteData=32'hF8F8F8F8, one edge; then RegWrite=0, ReadReg1=3, ReadReg2=3 -> both outputs = 32'hF8F8F8F8.
- Register 0 protection: RegWrite=1, WriteReg=0, WriteData=32'hFFFFFFFF, edge -> ReadReg1=0 gives 0; BYPASS=1 also gives 0 before the edge.
- Bypass:
  - BYPASS=1: reg7=32'h1, drive RegWrite=1, WriteReg=7, WriteData=32'hFBFBFBFB, ReadReg1=ReadReg2=7 -> both read 32'hFBFBFBFB before the edge.
  - BYPASS=0 instance: same stimulus reads 32'h1 before the edge and 32'hFBFBFBFB after it.
- Write disable: RegWrite=0, WriteReg=9, WriteData=32'hDEADBEEF over 3 edges -> reg9 retains its prior value 32'h00000009.
- Sweep: write reg[i]=i*32'h01010101 for i=1..31, then read all pairs (i, 31-i) -> every value matches; reg0=0.
